// File: rtl/pi_run_controller.sv
// pi_run_controller
// -----------------
// Runs one Monte Carlo pi-estimation run. A start command captures the sample
// count and clears the external hit accumulator. The block then requests
// samples from the generator/tester pipeline, never with more than PIPE_DEPTH
// results in flight. When every outstanding result has come back, it latches
// the final hit count and raises done.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        run command, accepted only in IDLE or DONE
//   abort        stop issuing, drain in-flight results, finish early
//   num_samples  number of samples to run, captured on an accepted start
//   smp_req      request one sample from the generator
//   smp_ack      generator accepts the request (issue = smp_req & smp_ack)
//   res_valid    one tester result returns
//   acc_enable   accumulator enable; its rising edge clears the accumulator
//   acc_result   accumulator hit count
//   busy         run in progress (CLEAR, RUN, DRAIN)
//   done         run finished, held until the next accepted start
//   aborted      last run was ended by abort
//   err          sticky: res_valid arrived with nothing outstanding
//   hits_out     latched hit count of the last run
//   total_out    number of samples actually issued in the last run
module pi_run_controller #(
    parameter int CNT_W      = 32,
    parameter int PIPE_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_samples,
    output logic             smp_req,
    input  logic             smp_ack,
    input  logic             res_valid,
    output logic             acc_enable,
    input  logic [CNT_W-1:0] acc_result,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err,
    output logic [CNT_W-1:0] hits_out,
    output logic [CNT_W-1:0] total_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(PIPE_DEPTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             aborted_q, aborted_d;
    logic             err_q, err_d;
    logic             issue;
    logic             retire;

    always_comb begin
        // NOTE: every signal gets a default before any branch; otherwise an
        // unassigned path would infer a latch.
        state_d   = state_q;
        target_d  = target_q;
        issued_d  = issued_q;
        outst_d   = outst_q;
        hits_d    = hits_q;
        total_d   = total_q;
        aborted_d = aborted_q;
        err_d     = err_q;

        // The request uses only registered state, plus the abort gate, which
        // has to stop issuing in the same cycle abort is raised.
        smp_req = (state_q == S_RUN) && (issued_q < target_q) &&
                  (outst_q < DEPTH) && !abort;
        issue   = smp_req && smp_ack;
        // A result that arrives with nothing in flight is counted as an error
        // and never retires anything, so the counter cannot underflow.
        retire  = res_valid && (outst_q != '0);

        if (res_valid && (outst_q == '0)) begin
            err_d = 1'b1;
        end

        if (issue && !retire) begin
            outst_d = outst_q + ONE;
        end else if (retire && !issue) begin
            outst_d = outst_q - ONE;
        end

        if (issue) begin
            issued_d = issued_q + ONE;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    target_d  = num_samples;
                    issued_d  = '0;
                    outst_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (target_q == '0) begin
                    // acc_result still holds the previous run's count this
                    // cycle, because the clear lands on this edge. An empty
                    // run therefore records zero directly.
                    hits_d  = '0;
                    total_d = '0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN;
                end else if (issued_q == target_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outst_q == '0) begin
                    hits_d  = acc_result;
                    total_d = issued_q;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from the values they held before the edge.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register is reset. The block holds no memory array, so
        // it costs little to return it to a fully known state.
        if (reset) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            issued_q  <= '0;
            outst_q   <= '0;
            hits_q    <= '0;
            total_q   <= '0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            issued_q  <= issued_d;
            outst_q   <= outst_d;
            hits_q    <= hits_d;
            total_q   <= total_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
        end
    end

    assign busy       = (state_q == S_CLEAR) || (state_q == S_RUN) ||
                        (state_q == S_DRAIN);
    assign acc_enable = busy;
    assign done       = (state_q == S_DONE);
    assign aborted    = aborted_q;
    assign err        = err_q;
    assign hits_out   = hits_q;
    assign total_out  = total_q;

endmodule

// File: tb/tb_pi_run_controller.sv
// Testbench for pi_run_controller. The bench models the generator/tester
// pipeline as an in-order queue with a configurable latency and hold-back
// probability. It also models the accumulator, which clears on the rising
// edge of acc_enable. Each start pushes the expected outcome of the run
// (hits, total, aborted) into a scoreboard queue. A separate monitor pops an
// entry whenever done rises and compares it with the DUT outputs.
module tb_pi_run_controller;

    localparam int CNT_W   = 32;
    localparam int DEPTH   = 4;
    localparam int NOABORT = 1 << 30;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_samples;
    logic             smp_req;
    logic             smp_ack;
    logic             res_valid;
    logic             res_hit;
    logic             acc_enable;
    logic [CNT_W-1:0] acc_result;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             err;
    logic [CNT_W-1:0] hits_out;
    logic [CNT_W-1:0] total_out;

    always #5 clk = ~clk;

    pi_run_controller #(.CNT_W(CNT_W), .PIPE_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .num_samples(num_samples),
        .smp_req    (smp_req),
        .smp_ack    (smp_ack),
        .res_valid  (res_valid),
        .acc_enable (acc_enable),
        .acc_result (acc_result),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .err        (err),
        .hits_out   (hits_out),
        .total_out  (total_out)
    );

    // External accumulator: cleared on the rising edge of acc_enable, counts
    // hits while enabled.
    logic acc_en_prev;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_result  <= '0;
            acc_en_prev <= 1'b0;
        end else begin
            acc_en_prev <= acc_enable;
            if (acc_enable && !acc_en_prev)
                acc_result <= '0;
            else if (acc_enable && res_valid && res_hit)
                acc_result <= acc_result + 1;
        end
    end

    typedef struct { int due; bit hit; } pend_t;
    typedef struct { int hits; int total; bit aborted; } exp_t;

    pend_t pipe_q[$];
    exp_t  exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int since_start = 0;
    int issued_cnt  = 0;
    int cur_n       = 0;
    int abort_at    = NOABORT;
    int lat         = 3;
    int ack_pct     = 100;
    int hold_pct    = 0;
    int sim_seen    = 0;
    bit err_model   = 1'b0;
    bit prev_done   = 1'b0;
    bit hit_plan [256];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_smp_req"}, smp_req, 0);
        check({tag, "_acc_enable"}, acc_enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_hits_out"}, hits_out, 0);
        check({tag, "_total_out"}, total_out, 0);
    endtask

    // One clock cycle of environment activity: drive the inputs on the
    // falling edge, then check smp_req against the run rules.
    task automatic tick(input bit st, input bit stray);
        bit returned;
        bit exp_req;
        int inflight;
        @(negedge clk);
        start    = st;
        returned = 1'b0;
        if (st) begin
            since_start = 0;
            issued_cnt  = 0;
        end
        res_valid = 1'b0;
        res_hit   = 1'b0;
        if (pipe_q.size() > 0 && cyc >= pipe_q[0].due &&
            int'($urandom_range(0, 99)) >= hold_pct) begin
            res_valid = 1'b1;
            res_hit   = pipe_q[0].hit;
            returned  = 1'b1;
            void'(pipe_q.pop_front());
        end
        if (stray) begin
            res_valid = 1'b1;
            res_hit   = 1'b0;
            err_model = 1'b1;
        end
        smp_ack = int'($urandom_range(0, 99)) < ack_pct;
        abort   = issued_cnt >= abort_at;
        #1;
        inflight = pipe_q.size() + (returned ? 1 : 0);
        exp_req  = (since_start >= 2) && (issued_cnt < cur_n) &&
                   (inflight < DEPTH) && !abort;
        check("smp_req", smp_req, exp_req);
        if (smp_req && smp_ack) begin
            if (returned && inflight == DEPTH - 1) sim_seen++;
            pipe_q.push_back(pend_t'{due: cyc + lat,
                                     hit: (issued_cnt < 256) ? hit_plan[issued_cnt] : 1'b0});
            issued_cnt++;
        end
        cyc++;
        since_start++;
    endtask

    task automatic start_run(input int n, input int ab);
        exp_t e;
        cur_n       = n;
        abort_at    = ab;
        num_samples = CNT_W'(n);
        e.total     = (ab < n) ? ab : n;
        e.aborted   = (ab < n);
        e.hits      = 0;
        for (int i = 0; i < e.total; i++) e.hits += int'(hit_plan[i]);
        exp_q.push_back(e);
        tick(1'b1, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick(1'b0, 1'b0);
            if (done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic clear_model();
        pipe_q.delete();
        exp_q.delete();
        issued_cnt = 0;
        cur_n      = 0;
        abort_at   = NOABORT;
        err_model  = 1'b0;
    endtask

    task automatic random_plan();
        for (int i = 0; i < 256; i++) hit_plan[i] = 1'($urandom_range(0, 1));
    endtask

    // Monitor: on every rising edge of done, compare the run outcome.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                check("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("hits_out", hits_out, e.hits);
                    check("total_out", total_out, e.total);
                    check("aborted", aborted, e.aborted);
                    check("err_at_done", err, err_model);
                    check("busy_at_done", busy, 0);
                    check("acc_enable_at_done", acc_enable, 0);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        int n;
        int ab;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        smp_ack     = 1'b0;
        res_valid   = 1'b0;
        res_hit     = 1'b0;
        num_samples = '0;
        #12;
        check_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // Basic run: 4 samples, results 3 cycles later, hits 1,0,1,1.
        hit_plan[0] = 1'b1; hit_plan[1] = 1'b0;
        hit_plan[2] = 1'b1; hit_plan[3] = 1'b1;
        lat = 3; ack_pct = 100; hold_pct = 0;
        start_run(4, NOABORT);
        wait_done(100);
        check("basic_issues", issued_cnt, 4);

        // Zero samples, started from DONE: CLEAR in cycle 1, DONE in cycle 2.
        start_run(0, NOABORT);
        tick(1'b0, 1'b0);
        check("zero_c1_done", done, 0);
        check("zero_c1_busy", busy, 1);
        check("zero_c1_acc_enable", acc_enable, 1);
        tick(1'b0, 1'b0);
        check("zero_c2_done", done, 1);
        check("zero_c2_busy", busy, 0);

        // Credit limit: results withheld, issuing stops at DEPTH.
        random_plan();
        lat = 1; hold_pct = 100;
        start_run(6, NOABORT);
        repeat (12) tick(1'b0, 1'b0);
        check("credit_issued", issued_cnt, DEPTH);
        hold_pct = 0;
        wait_done(100);

        // Abort after 10 issues in a 100-sample run with 3 in flight.
        random_plan();
        lat = 3; ack_pct = 100; hold_pct = 0;
        start_run(100, 10);
        wait_done(300);
        check("abort_issued", issued_cnt, 10);
        check("issue_and_return_at_depth_minus_1", sim_seen > 0, 1);

        // Reset asserted in the middle of a run clears every output at once.
        random_plan();
        start_run(50, NOABORT);
        repeat (8) tick(1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_zero("midrun_reset");
        clear_model();
        @(negedge clk);
        reset = 1'b0;

        // A stray result in IDLE sets err, which stays set.
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("err_set", err, 1);
        repeat (3) tick(1'b0, 1'b0);
        check("err_sticky", err, 1);

        // The next start runs normally.
        random_plan();
        start_run(5, NOABORT);
        wait_done(100);

        // Reset again so that err=0 is checked across the random runs.
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        @(negedge clk);
        reset = 1'b0;

        // Random runs: size, abort point, latency, ack and hold rates.
        repeat (25) begin
            random_plan();
            n  = int'($urandom_range(0, 20));
            ab = (n > 0 && $urandom_range(0, 3) == 0) ?
                 int'($urandom_range(0, n - 1)) : NOABORT;
            lat      = int'($urandom_range(1, 6));
            ack_pct  = int'($urandom_range(30, 100));
            hold_pct = int'($urandom_range(0, 60));
            repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0);
            start_run(n, ab);
            wait_done(2000);
        end
        tick(1'b0, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
